// File: rtl/dac_wfm_player.sv
// Waveform table player feeding the 4x DAC interface: loop or single-pass replay of 4-lane I/Q words.
// Optional frame counter output is built when WFM_FRAME_CNT_EN is defined.
module dac_wfm_player #(
  parameter int SAMPLE_W = 16,
  parameter int LANES    = 4,
  parameter int ADDR_W   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [2*LANES*SAMPLE_W-1:0] wr_data,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        one_shot,
  input  logic [ADDR_W-1:0]           loop_last,
  input  logic                        dac_ready,
  output logic [LANES*SAMPLE_W-1:0]   dac_i,
  output logic [LANES*SAMPLE_W-1:0]   dac_q,
  output logic                        dac_valid,
  output logic                        dac_sync,
  output logic                        busy
`ifdef WFM_FRAME_CNT_EN
  ,
  output logic [31:0]                 frame_cnt
`endif
);

  localparam int RAIL_W = LANES * SAMPLE_W;
  localparam int DATA_W = 2 * RAIL_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
  logic [ADDR_W-1:0] loop_last_r;
  logic              one_shot_r;
  logic              issue_s, accept_s;

  // Stage 0 holds the issued address, stage 1 the registered RAM word.
  logic              p0_valid_r, p1_valid_r, p1_sync_r;
  logic [ADDR_W-1:0] p0_addr_r;
  logic [DATA_W-1:0] p1_data_r;

  // Table write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // RAM read register; a read colliding with a write returns the old word.
  always_ff @(posedge clk) begin
    if (dac_ready) begin
      p1_data_r <= mem_r[p0_addr_r];
    end
  end

  // Next-state and read-address sequencing.
  always_comb begin
    state_s   = state_r;
    rd_addr_s = rd_addr_r;
    issue_s   = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          state_s   = RUN;
          rd_addr_s = '0;
          accept_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_s   = IDLE;
          rd_addr_s = '0;
        end else if (dac_ready) begin
          issue_s = 1'b1;
          if (rd_addr_r != loop_last_r) begin
            rd_addr_s = rd_addr_r + ADDR_ONE;
          end else if (one_shot_r) begin
            state_s   = DRAIN;
            rd_addr_s = '0;
          end else begin
            rd_addr_s = '0;
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        // Leaving DRAIN is gated by dac_ready so a frozen block stays put.
        if (stop || (dac_ready && !p0_valid_r && !p1_valid_r)) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s   = IDLE;
        rd_addr_s = '0;
      end
    endcase
  end

  // FSM state, read address and per-run configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_addr_r   <= '0;
      one_shot_r  <= 1'b0;
      loop_last_r <= '0;
      busy        <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_addr_r <= rd_addr_s;
      busy      <= (state_s != IDLE);
      if (accept_s) begin
        one_shot_r  <= one_shot;
        loop_last_r <= loop_last;
      end
    end
  end

  // Valid/sync pipeline and output register; stop flushes regardless of dac_ready.
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      p0_valid_r <= 1'b0;
      p0_addr_r  <= '0;
      p1_valid_r <= 1'b0;
      p1_sync_r  <= 1'b0;
      dac_valid  <= 1'b0;
      dac_sync   <= 1'b0;
      dac_i      <= '0;
      dac_q      <= '0;
    end else if (dac_ready) begin
      p0_valid_r <= issue_s;
      p0_addr_r  <= rd_addr_r;
      p1_valid_r <= p0_valid_r;
      p1_sync_r  <= p0_valid_r && (p0_addr_r == '0);
      dac_valid  <= p1_valid_r;
      dac_sync   <= p1_valid_r && p1_sync_r;
      dac_i      <= p1_valid_r ? p1_data_r[RAIL_W-1:0] : '0;
      dac_q      <= p1_valid_r ? p1_data_r[DATA_W-1:RAIL_W] : '0;
    end
  end

`ifdef WFM_FRAME_CNT_EN
  // Counts accepted sync words, saturating; restarts on every accepted start.
  always_ff @(posedge clk) begin
    if (rst || accept_s) begin
      frame_cnt <= 32'd0;
    end else if (dac_valid && dac_sync && dac_ready && (frame_cnt != 32'hFFFF_FFFF)) begin
      frame_cnt <= frame_cnt + 32'd1;
    end
  end
`else
  // Frame counter not built in this configuration.
`endif

endmodule
